// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM-subset controller:
// FSM states, instruction fields, datapath selects, condition evaluation.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // flags are {N, Z, C, V}; code 1111 never executes
  function automatic logic cond_check(
    input logic [3:0] cond,
    input logic [3:0] flags
  );
    logic n, z, c, v, r;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~(c & ~z);
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = ~(~z & (n == v));
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// Flags and latched condition result; gates the architectural
// write enables so failed-condition instructions have no effect.
module cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic       latch_cond,
  input  logic       flag_en,
  input  logic [1:0] flag_w,
  input  logic [3:0] alu_flags,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       next_pc,
  input  logic       branch,
  input  logic       no_write,
  input  logic       rd_pc,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write
);

  logic [3:0] flags;
  logic       cond_ex_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      if (latch_cond)
        cond_ex_reg <= cond_check(cond, flags);
      if (flag_en && cond_ex_reg) begin
        if (flag_w[1])
          flags[3:2] <= alu_flags[3:2];
        if (flag_w[0])
          flags[1:0] <= alu_flags[1:0];
      end
    end
  end

  logic reg_ok;

  assign reg_ok    = reg_w & ~no_write;
  assign reg_write = reg_ok & cond_ex_reg & ~reset;
  assign mem_write = mem_w & cond_ex_reg & ~reset;
  assign pc_write  = (next_pc
                    | (cond_ex_reg & (branch | (reg_ok & rd_pc))))
                    & ~reset;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset controller: IR decode, per-instruction
// sequencing FSM and datapath select generation.
module multicycle_controller
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  State
);

  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       i_bit, s_bit;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign i_bit     = funct[5];
  assign cmd       = funct[4:1];
  assign s_bit     = funct[0];
  assign unused_rn = ^Instr[7:4];

  state_t state, next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= FETCH;
    else
      state <= next;
  end

  logic       ir_write, next_pc, reg_w, mem_w;
  logic       branch, alu_op;
  logic       adr_src, src_a;
  logic [1:0] src_b, res_src;

  always_comb begin
    next     = state;
    ir_write = 1'b0;
    next_pc  = 1'b0;
    reg_w    = 1'b0;
    mem_w    = 1'b0;
    branch   = 1'b0;
    alu_op   = 1'b0;
    adr_src  = 1'b0;
    src_a    = 1'b0;
    src_b    = SRCB_REG;
    res_src  = RES_ALUOUT;
    case (state)
      FETCH: begin
        ir_write = 1'b1;
        next_pc  = 1'b1;
        src_a    = 1'b1;
        src_b    = SRCB_FOUR;
        res_src  = RES_ALU;
        next     = DECODE;
      end
      DECODE: begin
        src_a   = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RES_ALU;
        case (op)
          OP_MEM:  next = MEMADR;
          OP_DP:   next = i_bit ? EXECUTEI : EXECUTER;
          OP_B:    next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        src_b = SRCB_IMM;
        next  = s_bit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next    = MEMWB;
      end
      MEMWB: begin
        res_src = RES_DATA;
        reg_w   = 1'b1;
        next    = FETCH;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        next    = FETCH;
      end
      EXECUTER: begin
        src_b  = SRCB_REG;
        alu_op = 1'b1;
        next   = ALUWB;
      end
      EXECUTEI: begin
        src_b  = SRCB_IMM;
        alu_op = 1'b1;
        next   = ALUWB;
      end
      ALUWB: begin
        res_src = RES_ALUOUT;
        reg_w   = 1'b1;
        next    = FETCH;
      end
      BRANCH: begin
        src_b   = SRCB_IMM;
        res_src = RES_ALU;
        branch  = 1'b1;
        next    = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  logic [1:0] alu_dec;
  logic       cmd_ok;

  always_comb begin
    alu_dec = ALU_ADD;
    cmd_ok  = 1'b1;
    unique case (1'b1)
      cmd == CMD_ADD: alu_dec = ALU_ADD;
      cmd == CMD_SUB: alu_dec = ALU_SUB;
      cmd == CMD_CMP: alu_dec = ALU_SUB;
      cmd == CMD_AND: alu_dec = ALU_AND;
      cmd == CMD_ORR: alu_dec = ALU_ORR;
      default:        cmd_ok  = 1'b0;
    endcase
  end

  logic       no_write, reg_w_ok;
  logic [1:0] flag_w;

  // unsupported data-processing commands behave as NOPs
  assign reg_w_ok  = reg_w & ~((op == OP_DP) & ~cmd_ok);
  assign no_write  = (cmd == CMD_CMP);
  assign flag_w[1] = s_bit | (cmd == CMD_CMP);
  assign flag_w[0] = flag_w[1]
                   & ((cmd == CMD_ADD)
                   | (cmd == CMD_SUB)
                   | (cmd == CMD_CMP));

  cond_unit u_cond (
    .clk        (clk),
    .reset      (reset),
    .cond       (cond),
    .latch_cond (state == DECODE),
    .flag_en    ((state == EXECUTER)
               | (state == EXECUTEI)),
    .flag_w     (flag_w),
    .alu_flags  (ALUFlags),
    .reg_w      (reg_w_ok),
    .mem_w      (mem_w),
    .next_pc    (next_pc),
    .branch     (branch),
    .no_write   (no_write),
    .rd_pc      (rd == 4'b1111),
    .reg_write  (RegWrite),
    .mem_write  (MemWrite),
    .pc_write   (PCWrite)
  );

  assign IRWrite    = ir_write & ~reset;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign ResultSrc  = res_src;
  assign ALUControl = alu_op ? alu_dec : ALU_ADD;
  assign RegSrc     = {op == OP_MEM, op == OP_B};
  assign ImmSrc     = op;
  assign State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vector bench for multicycle_controller,
// plus a mid-instruction reset sequence.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
  logic        ALUSrcA;
  logic [3:0]  State;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .State      (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] S_FE = 4'd0;
  localparam logic [3:0] S_DE = 4'd1;
  localparam logic [3:0] S_MA = 4'd2;
  localparam logic [3:0] S_MR = 4'd3;
  localparam logic [3:0] S_MB = 4'd4;
  localparam logic [3:0] S_MW = 4'd5;
  localparam logic [3:0] S_XR = 4'd6;
  localparam logic [3:0] S_AW = 4'd8;
  localparam logic [3:0] S_BR = 4'd9;

  localparam logic [31:0] ADD   = 32'hE0821003;
  localparam logic [31:0] LDR   = 32'hE5904008;
  localparam logic [31:0] SUBS  = 32'hE0555005;
  localparam logic [31:0] BEQ   = 32'h0A000002;
  localparam logic [31:0] STRNE = 32'h15801000;
  localparam logic [31:0] UND   = 32'hEC000000;
  localparam logic [31:0] CMP   = 32'hE1500001;
  localparam logic [31:0] BMI   = 32'h4A000000;
  localparam logic [31:0] ADDPC = 32'hE082F003;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [3:0]  fl;
    logic        rst;
    logic [3:0]  st;
    logic        pcw, irw, rw, mw, adr, sa;
    logic [1:0]  sb, ctl, res;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl[$];

  function automatic vec_t mk(
    input string n, input logic [31:0] ir,
    input logic [3:0] fl, input logic rst,
    input logic [3:0] st,
    input logic pcw, input logic irw,
    input logic rw, input logic mw,
    input logic adr, input logic sa,
    input logic [1:0] sb, input logic [1:0] ctl,
    input logic [1:0] res
  );
    vec_t v;
    v.name = n; v.ir = ir; v.fl = fl; v.rst = rst;
    v.st = st; v.pcw = pcw; v.irw = irw; v.rw = rw;
    v.mw = mw; v.adr = adr; v.sa = sa;
    v.sb = sb; v.ctl = ctl; v.res = res;
    return v;
  endfunction

  function automatic vec_t fe(input string n, input logic [31:0] ir);
    return mk(n, ir, 4'h0, 1'b0, S_FE, 1, 1, 0, 0, 0, 1, 2'd2, 2'd0, 2'd2);
  endfunction

  function automatic vec_t de(input string n, input logic [31:0] ir);
    return mk(n, ir, 4'h0, 1'b0, S_DE, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd2);
  endfunction

  task automatic run(input vec_t v);
    logic [1:0]  op;
    logic [19:0] act, exp;
    reset    = v.rst;
    Instr    = v.ir[31:12];
    ALUFlags = v.fl;
    #1;
    op  = v.ir[27:26];
    exp = {v.st, v.pcw, v.irw, v.rw, v.mw, v.adr, v.sa,
           v.sb, v.ctl, v.res, op, op == 2'b01, op == 2'b10};
    act = {State, PCWrite, IRWrite, RegWrite, MemWrite,
           AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc,
           ImmSrc, RegSrc};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", v.name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    reset    = 1'b1;
    Instr    = '0;
    ALUFlags = '0;
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mk("rst_hold", ADD, 0, 1, S_FE, 0, 0, 0, 0, 0, 1, 2, 0, 2));
    tbl.push_back(fe("add_fe", ADD));
    tbl.push_back(de("add_de", ADD));
    tbl.push_back(mk("add_ex", ADD, 0, 0, S_XR, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("add_wb", ADD, 0, 0, S_AW, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(fe("ldr_fe", LDR));
    tbl.push_back(de("ldr_de", LDR));
    tbl.push_back(mk("ldr_ma", LDR, 0, 0, S_MA, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("ldr_mr", LDR, 0, 0, S_MR, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("ldr_mb", LDR, 0, 0, S_MB, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(fe("subs_fe", SUBS));
    tbl.push_back(de("subs_de", SUBS));
    tbl.push_back(mk("subs_ex", SUBS, 4'b0100, 0, S_XR, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("subs_wb", SUBS, 0, 0, S_AW, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(fe("beq_fe", BEQ));
    tbl.push_back(de("beq_de", BEQ));
    tbl.push_back(mk("beq_taken", BEQ, 0, 0, S_BR, 1, 0, 0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(fe("subs0_fe", SUBS));
    tbl.push_back(de("subs0_de", SUBS));
    tbl.push_back(mk("subs0_ex", SUBS, 4'b0000, 0, S_XR, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("subs0_wb", SUBS, 0, 0, S_AW, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(fe("beq2_fe", BEQ));
    tbl.push_back(de("beq2_de", BEQ));
    tbl.push_back(mk("beq_not", BEQ, 0, 0, S_BR, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(fe("subsz_fe", SUBS));
    tbl.push_back(de("subsz_de", SUBS));
    tbl.push_back(mk("subsz_ex", SUBS, 4'b0100, 0, S_XR, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("subsz_wb", SUBS, 0, 0, S_AW, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(fe("strne_fe", STRNE));
    tbl.push_back(de("strne_de", STRNE));
    tbl.push_back(mk("strne_ma", STRNE, 0, 0, S_MA, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("strne_mw", STRNE, 0, 0, S_MW, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(fe("und_fe", UND));
    tbl.push_back(de("und_de", UND));
    tbl.push_back(fe("cmp_fe", CMP));
    tbl.push_back(de("cmp_de", CMP));
    tbl.push_back(mk("cmp_ex", CMP, 4'b1000, 0, S_XR, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("cmp_wb", CMP, 0, 0, S_AW, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(fe("bmi_fe", BMI));
    tbl.push_back(de("bmi_de", BMI));
    tbl.push_back(mk("bmi_taken", BMI, 0, 0, S_BR, 1, 0, 0, 0, 0, 0, 1, 0, 2));
    tbl.push_back(fe("addpc_fe", ADDPC));
    tbl.push_back(de("addpc_de", ADDPC));
    tbl.push_back(mk("addpc_ex", ADDPC, 0, 0, S_XR, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("addpc_wb", ADDPC, 0, 0, S_AW, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(fe("ldr2_fe", LDR));

    foreach (tbl[i]) run(tbl[i]);

    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (State == S_MR) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL wait_memread: got state %0d expected %0d", State, S_MR);
    end

    run(mk("rst_async", LDR, 0, 1, S_FE, 0, 0, 0, 0, 0, 1, 2, 0, 2));
    run(mk("rst_hold2", LDR, 0, 1, S_FE, 0, 0, 0, 0, 0, 1, 2, 0, 2));
    run(fe("rst_rel_fe", BMI));
    run(de("bmi2_de", BMI));
    run(mk("bmi_flags_clr", BMI, 0, 0, S_BR, 0, 0, 0, 0, 0, 0, 1, 0, 2));
    run(fe("end_fe", ADD));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing controller for the multicycle variant of the ARM-subset datapath, with shared instruction/data memory and IR/ALUOut/Data registers.
- Decodes the instruction register, runs the per-instruction state machine and holds the NZCV flags.
- Produces all datapath mux selects and gated write enables each cycle.
- Supports data-processing (ADD, SUB, AND, ORR, CMP; register or immediate), LDR/STR with immediate offset, and B. Every instruction is conditional.

Parameters:
- RESET_STATE, FETCH, state entered on reset (fixed by the package; not overridable in practice).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Instr  in  20  IR bits [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  in  4  NZCV from the ALU, this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  IR enable
- RegWrite  out  1  register file write enable
- RegSrc  out  2  bit0: RA1 = R15; bit1: RA2 = Rd
- ImmSrc  out  2  extend select (equals op)
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- State  out  4  current state encoding, for debug and the bench

Behaviour:
- Reset: asynchronous; State = FETCH, Flags = 0000, CondExReg = 0. While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Decode fields:
  - I = funct[5], cmd = funct[4:1], S = funct[0], L = funct[0].
  - ALUControl when ALUOp = 1: cmd 0100 → 00, 0010 → 01, 0000 → 10, 1100 → 11, 1010 (CMP) → 01. Other cmd values → 00, with RegW suppressed (NOP).
  - ALUControl is 00 whenever ALUOp = 0.
  - NoWrite = (cmd == 1010).
  - FlagW[1] (NZ) = S | CMP.
  - FlagW[0] (CV) = FlagW[1] & cmd ∈ {ADD, SUB, CMP}.
- Condition check:
  - Standard ARM codes 0000–1110, evaluated on the registered Flags.
  - Code 1111 → CondEx = 0.
  - CondEx is registered into CondExReg at the edge leaving DECODE. All later states use CondExReg.
- Flag update: at the edge leaving EXECUTER or EXECUTEI, if CondExReg = 1:
  - Flags[3:2] ← ALUFlags[3:2] when FlagW[1];
  - Flags[1:0] ← ALUFlags[1:0] when FlagW[0].
- States, Moore outputs (unlisted selects are 0) and next state:
  - FETCH: IRWrite, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC. Next: DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next by op:
    - op 01 → MEMADR;
    - op 00 → EXECUTEI if I, else EXECUTER;
    - op 10 → BRANCH;
    - op 11 → FETCH (undefined instruction, no side effects).
  - MEMADR: ALUSrcB=01. Next: MEMREAD if L, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegW. Next: FETCH.
  - MEMWRITE: AdrSrc=1, MemW. Next: FETCH.
  - EXECUTER: ALUSrcB=00, ALUOp. Next: ALUWB.
  - EXECUTEI: ALUSrcB=01, ALUOp. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegW. Next: FETCH.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch. Next: FETCH.
- Decode-derived outputs, valid in every state:
  - RegSrc[0] = (op == 10);
  - RegSrc[1] = (op == 01);
  - ImmSrc = op.
- Gated enables:
  - RegWrite = RegW & CondExReg & ~NoWrite.
  - MemWrite = MemW & CondExReg.
  - PCWrite = NextPC | (CondExReg & (Branch | (RegW & ~NoWrite & Rd == 1111))).
- Latency: 3 cycles for branch, 4 for data-processing and STR, 5 for LDR. A failed condition does not shorten the sequence.
- Reset mid-instruction: return to FETCH immediately and clear Flags. No write enable pulses in the reset cycle or in the following FETCH until reset deasserts.

Decomposition:
- Package arm_mc_pkg holds:
  - state_t enum (4-bit: FETCH=0 … BRANCH=9);
  - op, cmd and cond constants;
  - ALUSrcB, ResultSrc and ALUControl encodings.
- Sub-module cond_unit holds the Flags register, CondExReg, condition evaluation and gated-enable logic.
- The FSM and decoder stay in the top module.

Test Plan:
- Reset, then release with Instr=0xE0821003 (ADD R1,R2,R3) → states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUControl=00 in EXECUTER; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- Instr=0xE5904008 (LDR R4,[R0,#8]) → 5-cycle sequence. AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB; ImmSrc=01.
- Instr=0xE0555005 (SUBS R5,R5,R5) with ALUFlags=0100 in EXECUTER → Flags=0100. Next, Instr=0x0A000002 (BEQ) → BRANCH with PCWrite=1. Repeat with Flags=0000 → PCWrite=0 in BRANCH.
- Instr=0x15801000 (STRNE) with Z=1 → MemWrite stays 0 throughout; sequence still returns to FETCH after MEMWRITE.
- Instr=0xE1500001 (CMP R0,R1), ALUFlags=1000 → RegWrite=0 in ALUWB, Flags=1000. Instr=0xE082F003 (ADD PC,…) → PCWrite=1 in ALUWB.
- Assert reset during MEMREAD → State=FETCH at once, Flags=0000, no MemWrite/RegWrite/IRWrite/PCWrite while reset is high.
